// File: rtl/rotation_cordic.sv
`default_nettype none
// ============================================================================
// Module   : rotation_cordic
// Purpose  : Iterative rotation-mode CORDIC with gain compensation. Define
//            ROT_CORDIC_SAT_EN to saturate (instead of wrap) the scaled result.
// Revision : 1.0 - initial release
// ============================================================================
module rotation_cordic #(
    parameter int WORDLEN                  = 16,
    parameter int N_STAGES                 = 12,
    parameter int COUNTLEN                 = 4,
    parameter logic [WORDLEN-1:0] SCALING_FACTOR = 16'h09b8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WORDLEN-1:0] regfile_out1,
    input  logic [WORDLEN-1:0] regfile_out2,
    input  logic [WORDLEN-1:0] theta_in,
    input  logic               valid_rot,
    output logic [WORDLEN-1:0] rot_out_x,
    output logic [WORDLEN-1:0] rot_out_y,
    output logic               done_rot,
    output logic               busy_rot
);

    localparam int XW = WORDLEN + 2;
    localparam int PW = XW + WORDLEN;
    localparam logic signed [WORDLEN-1:0] c_half_pi = WORDLEN'(16'h1922);
    localparam logic signed [WORDLEN-1:0] c_pi      = WORDLEN'(16'h3244);
    localparam logic [COUNTLEN-1:0]       c_last    = COUNTLEN'(N_STAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ITER  = 3'd2,
        S_SCALE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                     r_state, w_next_state;
    logic signed [XW-1:0]       r_x, r_y;
    logic signed [WORDLEN-1:0]  r_z;
    logic [COUNTLEN-1:0]        r_iter;
    logic [WORDLEN-1:0]         r_sx, r_sy;
    logic [WORDLEN-1:0]         r_out_x, r_out_y;
    logic                       r_done;

    logic signed [XW-1:0]       w_xs, w_ys;
    logic                       w_dpos;
    logic signed [PW-1:0]       w_px, w_py, w_sx, w_sy;

    function automatic logic signed [WORDLEN-1:0] f_atan(input logic [COUNTLEN-1:0] i);
        case (i)
            4'd0:    f_atan = WORDLEN'(16'h0c90);
            4'd1:    f_atan = WORDLEN'(16'h076b);
            4'd2:    f_atan = WORDLEN'(16'h03eb);
            4'd3:    f_atan = WORDLEN'(16'h01fd);
            4'd4:    f_atan = WORDLEN'(16'h00ff);
            4'd5:    f_atan = WORDLEN'(16'h007f);
            4'd6:    f_atan = WORDLEN'(16'h003f);
            4'd7:    f_atan = WORDLEN'(16'h001f);
            4'd8:    f_atan = WORDLEN'(16'h000f);
            4'd9:    f_atan = WORDLEN'(16'h0007);
            4'd10:   f_atan = WORDLEN'(16'h0003);
            4'd11:   f_atan = WORDLEN'(16'h0001);
            default: f_atan = '0;
        endcase
    endfunction

    // Reduce the shifted product to WORDLEN bits.
    function automatic logic [WORDLEN-1:0] f_narrow(input logic signed [PW-1:0] v);
`ifdef ROT_CORDIC_SAT_EN
        if (v[PW-1:WORDLEN-1] != {(PW-WORDLEN+1){v[PW-1]}})
            f_narrow = v[PW-1] ? {1'b1, {(WORDLEN-1){1'b0}}} : {1'b0, {(WORDLEN-1){1'b1}}};
        else
            f_narrow = v[WORDLEN-1:0];
`else
        f_narrow = v[WORDLEN-1:0];
`endif
    endfunction

    assign w_xs   = r_x >>> r_iter;
    assign w_ys   = r_y >>> r_iter;
    assign w_dpos = ~r_z[WORDLEN-1];

    assign w_px = {{WORDLEN{r_x[XW-1]}}, r_x} * {{XW{SCALING_FACTOR[WORDLEN-1]}}, SCALING_FACTOR};
    assign w_py = {{WORDLEN{r_y[XW-1]}}, r_y} * {{XW{SCALING_FACTOR[WORDLEN-1]}}, SCALING_FACTOR};
    assign w_sx = w_px >>> N_STAGES;
    assign w_sy = w_py >>> N_STAGES;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (valid_rot) w_next_state = S_PRE;
            S_PRE:   w_next_state = S_ITER;
            S_ITER:  if (r_iter == c_last) w_next_state = S_SCALE;
            S_SCALE: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_out_x <= '0;
            r_out_y <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_rot) begin
                        r_x    <= {{(XW-WORDLEN){regfile_out1[WORDLEN-1]}}, regfile_out1};
                        r_y    <= {{(XW-WORDLEN){regfile_out2[WORDLEN-1]}}, regfile_out2};
                        r_z    <= theta_in;
                        r_iter <= '0;
                    end
                end
                S_PRE: begin
                    // Fold angles beyond +/-pi/2 into range by a half-turn.
                    if (r_z > c_half_pi) begin
                        r_x <= -r_x;
                        r_y <= -r_y;
                        r_z <= r_z - c_pi;
                    end else if (r_z < -c_half_pi) begin
                        r_x <= -r_x;
                        r_y <= -r_y;
                        r_z <= r_z + c_pi;
                    end
                end
                S_ITER: begin
                    if (w_dpos) begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - f_atan(r_iter);
                    end else begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + f_atan(r_iter);
                    end
                    r_iter <= r_iter + 1'b1;
                end
                S_SCALE: begin
                    r_sx <= f_narrow(w_sx);
                    r_sy <= f_narrow(w_sy);
                end
                S_DONE: begin
                    r_out_x <= r_sx;
                    r_out_y <= r_sy;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rot_out_x = r_out_x;
    assign rot_out_y = r_out_y;
    assign done_rot  = r_done;
    assign busy_rot  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rotation_cordic.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotation_cordic
// Purpose  : Directed self-checking bench for rotation_cordic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rotation_cordic;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] regfile_out1 = '0;
    logic [15:0] regfile_out2 = '0;
    logic [15:0] theta_in = '0;
    logic        valid_rot = 1'b0;
    logic [15:0] rot_out_x, rot_out_y;
    logic        done_rot, busy_rot;

    int total = 0;
    int bad   = 0;

    rotation_cordic dut (
        .CLK          (CLK),
        .RST          (RST),
        .regfile_out1 (regfile_out1),
        .regfile_out2 (regfile_out2),
        .theta_in     (theta_in),
        .valid_rot    (valid_rot),
        .rot_out_x    (rot_out_x),
        .rot_out_y    (rot_out_y),
        .done_rot     (done_rot),
        .busy_rot     (busy_rot)
    );

    always #5 CLK = ~CLK;

    function automatic int absdiff(input logic [15:0] a, input logic [15:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        return (d < 0) ? -d : d;
    endfunction

    // Caller sits just after a rising edge; valid is sampled on the next edge.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic [15:0] th,
                          output int lat, output logic busy_mid);
        regfile_out1 = x;
        regfile_out2 = y;
        theta_in     = th;
        valid_rot    = 1'b1;
        @(posedge CLK); #1;
        valid_rot = 1'b0;
        lat = -1;
        busy_mid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK); #1;
            if (c == 6) busy_mid = busy_rot;
            if (done_rot) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if (rot_out_x !== 16'h0 || rot_out_y !== 16'h0 || done_rot !== 1'b0 || busy_rot !== 1'b0) begin
            bad++;
            $display("FAIL reset: got x=%h y=%h done=%b busy=%b want all 0", rot_out_x, rot_out_y, done_rot, busy_rot);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_rot_pi2;
        int lat; logic bm;
        run_op(16'h1000, 16'h0000, 16'h1922, lat, bm);
        total++;
        if (lat !== 15) begin bad++; $display("FAIL t1_latency: got %0d want 15", lat); end
        total++;
        if (bm !== 1'b1) begin bad++; $display("FAIL t1_busy: got %b want 1", bm); end
        total++;
        if (absdiff(rot_out_x, 16'h0000) > 8) begin bad++; $display("FAIL t1_x: got %h want 0000+/-8", rot_out_x); end
        total++;
        if (absdiff(rot_out_y, 16'h1000) > 8) begin bad++; $display("FAIL t1_y: got %h want 1000+/-8", rot_out_y); end
        // Pulse must drop and results hold.
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if (done_rot !== 1'b0 || busy_rot !== 1'b0 || absdiff(rot_out_y, 16'h1000) > 8) begin
            bad++;
            $display("FAIL t1_hold: got done=%b busy=%b y=%h want done=0 busy=0 y~1000", done_rot, busy_rot, rot_out_y);
        end
    endtask

    task automatic test_rot_neg_pi4;
        int lat; logic bm;
        run_op(16'h1000, 16'h1000, 16'hF370, lat, bm);
        total++;
        if (lat !== 15) begin bad++; $display("FAIL t2_latency: got %0d want 15", lat); end
        total++;
        if (absdiff(rot_out_x, 16'h16A1) > 8) begin bad++; $display("FAIL t2_x: got %h want 16a1+/-8", rot_out_x); end
        total++;
        if (absdiff(rot_out_y, 16'h0000) > 8) begin bad++; $display("FAIL t2_y: got %h want 0000+/-8", rot_out_y); end
        @(posedge CLK); #1;
    endtask

    task automatic test_fold;
        int lat; logic bm;
        run_op(16'h1000, 16'h0000, 16'h3244, lat, bm);
        total++;
        if (absdiff(rot_out_x, 16'hF000) > 8 || absdiff(rot_out_y, 16'h0000) > 8) begin
            bad++; $display("FAIL t3_fold_pos_pi: got x=%h y=%h want f000/0000+/-8", rot_out_x, rot_out_y);
        end
        @(posedge CLK); #1;
        run_op(16'h0000, 16'h1000, 16'hCDBC, lat, bm);
        total++;
        if (absdiff(rot_out_x, 16'h0000) > 8 || absdiff(rot_out_y, 16'hF000) > 8) begin
            bad++; $display("FAIL fold_neg_pi: got x=%h y=%h want 0000/f000+/-8", rot_out_x, rot_out_y);
        end
        @(posedge CLK); #1;
        // -pi/2 exactly is not folded: (1,0) -> (0,-1)
        run_op(16'h1000, 16'h0000, 16'hE6DE, lat, bm);
        total++;
        if (absdiff(rot_out_x, 16'h0000) > 8 || absdiff(rot_out_y, 16'hF000) > 8) begin
            bad++; $display("FAIL neg_pi2: got x=%h y=%h want 0000/f000+/-8", rot_out_x, rot_out_y);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_saturation;
        int lat; logic bm;
        run_op(16'h7000, 16'h7000, 16'h0C90, lat, bm);
        total++;
        if (absdiff(rot_out_x, 16'h0000) > 8) begin bad++; $display("FAIL t4_x: got %h want 0000+/-8", rot_out_x); end
`ifdef ROT_CORDIC_SAT_EN
        total++;
        if (rot_out_y !== 16'h7FFF) begin bad++; $display("FAIL t4_y_sat: got %h want 7fff", rot_out_y); end
`else
        total++;
        if (absdiff(rot_out_y, 16'h9E6E) > 8) begin bad++; $display("FAIL t4_y_wrap: got %h want 9e6e+/-8", rot_out_y); end
`endif
        @(posedge CLK); #1;
    endtask

    task automatic test_ignore_valid;
        int dones;
        logic [15:0] cx, cy;
        dones = 0; cx = '0; cy = '0;
        regfile_out1 = 16'h1000; regfile_out2 = 16'h1000; theta_in = 16'hF370;
        valid_rot = 1'b1;
        @(posedge CLK); #1;
        valid_rot = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                regfile_out1 = 16'h1000; regfile_out2 = 16'h0000; theta_in = 16'h1922;
                valid_rot = 1'b1;
            end
            if (c == 8) valid_rot = 1'b0;
            @(posedge CLK); #1;
            if (done_rot) begin
                dones++;
                cx = rot_out_x; cy = rot_out_y;
            end
        end
        total++;
        if (dones !== 1) begin bad++; $display("FAIL t5_done_count: got %0d want 1", dones); end
        total++;
        if (absdiff(cx, 16'h16A1) > 8 || absdiff(cy, 16'h0000) > 8) begin
            bad++; $display("FAIL t5_result: got x=%h y=%h want 16a1/0000+/-8", cx, cy);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic bm;
        run_op(16'h1000, 16'h0000, 16'h1922, lat, bm);
        // Issue the next request in the done cycle itself.
        run_op(16'h1000, 16'h1000, 16'hF370, lat, bm);
        total++;
        if (lat !== 15) begin bad++; $display("FAIL b2b_latency: got %0d want 15", lat); end
        total++;
        if (absdiff(rot_out_x, 16'h16A1) > 8 || absdiff(rot_out_y, 16'h0000) > 8) begin
            bad++; $display("FAIL b2b_result: got x=%h y=%h want 16a1/0000+/-8", rot_out_x, rot_out_y);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid;
        int lat; int dones; logic bm;
        dones = 0;
        regfile_out1 = 16'h1000; regfile_out2 = 16'h0000; theta_in = 16'h1922;
        valid_rot = 1'b1;
        @(posedge CLK); #1;
        valid_rot = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        total++;
        if (rot_out_x !== 16'h0 || rot_out_y !== 16'h0 || busy_rot !== 1'b0 || done_rot !== 1'b0) begin
            bad++;
            $display("FAIL t6_reset_mid: got x=%h y=%h busy=%b done=%b want all 0", rot_out_x, rot_out_y, busy_rot, done_rot);
        end
        RST = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK); #1;
            if (done_rot) dones++;
        end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL t6_no_done: got %0d want 0", dones); end
        run_op(16'h1000, 16'h0000, 16'h3244, lat, bm);
        total++;
        if (lat !== 15 || absdiff(rot_out_x, 16'hF000) > 8 || absdiff(rot_out_y, 16'h0000) > 8) begin
            bad++;
            $display("FAIL t6_fresh: got lat=%0d x=%h y=%h want 15 f000/0000+/-8", lat, rot_out_x, rot_out_y);
        end
    endtask

    initial begin
        test_reset();
        test_rot_pi2();
        test_rot_neg_pi4();
        test_fold();
        test_saturation();
        test_ignore_valid();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
